// File: rtl/dm_ctrl.sv
// Data memory with MIPS byte/halfword/word access, sign/zero extension,
// misalignment rejection, registered read data and a post-reset clear sequencer.
module dm_ctrl #(
    parameter int unsigned ADDR_W         = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              misalign_o
);

    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned Depth = 1 << IdxW;

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
    logic            clr_we;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     mem_q [Depth];

    logic [IdxW-1:0] word_idx;
    logic [1:0]      lane;
    logic            accept;
    logic            misaligned;
    logic            store_en;
    logic            load_en;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_ext;

    assign word_idx = addr_i[ADDR_W-1:2];
    assign lane     = addr_i[1:0];
    // Requests are only honoured once the clear has finished.
    assign accept   = req_i & ready_q;

    // Clear sequencer: walk every word once after reset, then sit in idle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            StInit: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = StIdle;
                end
            end
            StIdle:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Registered so ready rises on the edge that leaves the clear.
        ready_d = (state_d == StIdle);
    end

    // Alignment check and store lane enables / replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wd         = wdata_i;
        case (size_i)
            2'b00: begin
                be        = 4'b0001 << lane;
                wd        = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wd         = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = |lane;
                be         = 4'b1111;
                wd         = wdata_i;
            end
            default: misaligned = 1'b1;
        endcase
        store_en = accept & we_i & ~misaligned;
        load_en  = accept & ~we_i & ~misaligned;
    end

    // Load lane selection and extension, plus next values of the response registers.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_i)
            2'b00:   ld_ext = {{24{sign_ext_i & rd_byte[7]}}, rd_byte};
            2'b01:   ld_ext = {{16{sign_ext_i & rd_half[15]}}, rd_half};
            default: ld_ext = rd_word;
        endcase

        rvalid_d   = load_en;
        misalign_d = accept & misaligned;
        rdata_d    = rdata_q;
        if (misalign_d) begin
            rdata_d = 32'h0;
        end else if (load_en) begin
            rdata_d = ld_ext;
        end
    end

    // Control and response state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if (CLEAR_ON_RESET) begin
                state_q <= StInit;
            end else begin
                state_q <= StIdle;
            end
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
        end
    end

    // Memory array: clear writes and byte-enabled stores (never both, ready gates stores).
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= 32'h0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    assign ready_o    = ready_q;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: byte-array reference model, directed and random accesses,
// clear timing after reset and after a reset in the middle of the clear.
module tb_dm_ctrl;

    localparam int AW    = 6;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected responses: bit 32 = misalign, [31:0] = rdata.
    logic [32:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  mdl[64];

    dm_ctrl #(
        .ADDR_W        (AW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .we_i      (we),
        .size_i    (size),
        .sign_ext_i(sext),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .ready_o   (ready),
        .rdata_o   (rdata),
        .rvalid_o  (rvalid),
        .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every expected response must appear exactly one edge after its request was accepted.
    always @(posedge clk) begin
        logic [32:0] e;
        string       nm;
        #1;
        if (rst_n === 1'b1) begin
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, "_rvalid"}, 32'(rvalid), 32'(!e[32]));
                chk({nm, "_misalign"}, 32'(misalign), 32'(e[32]));
                chk({nm, "_rdata"}, rdata, e[31:0]);
            end else if (rvalid !== 1'b0 || misalign !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_response: rvalid=%b misalign=%b expected none",
                         rvalid, misalign);
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                               input int a);
        logic [31:0] v;
        v = 32'h0;
        if (sz == 2'd0) begin
            v = 32'(mdl[a]);
            if (sx && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = 32'(mdl[a]) + 256 * 32'(mdl[a+1]);
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            for (int i = 0; i < 4; i++) v = v + (32'(mdl[a+i]) << (8 * i));
        end
        return v;
    endfunction

    // Drive one request once ready; record its expected outcome in the model/scoreboard.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input int a,
                         input logic [31:0] wd, input logic use_exp,
                         input logic [31:0] exp_val, input string nm);
        int  guard;
        bit  mis;
        guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 100) begin
            req = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: ready=%b expected 1 within 100 cycles", ready);
            return;
        end
        req   = 1'b1;
        we    = w;
        size  = sz;
        sext  = sx;
        addr  = AW'(a);
        wdata = wd;
        mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        if (mis) begin
            exp_q.push_back({1'b1, 32'h0});
            name_q.push_back({nm, "_mis"});
        end else if (w) begin
            for (int i = 0; i < (1 << sz); i++) mdl[a+i] = 8'(wd >> (8 * i));
        end else begin
            exp_q.push_back({1'b0, use_exp ? exp_val : model_load(sz, sx, a)});
            name_q.push_back(nm);
        end
    endtask

    task automatic st(input logic [1:0] sz, input int a, input logic [31:0] wd);
        issue(1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, "store");
    endtask

    task automatic ld(input logic [1:0] sz, input logic sx, input int a, input logic [31:0] e,
                      input string nm);
        issue(1'b0, sz, sx, a, 32'h0, 1'b1, e, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    // Counts edges from reset release until ready is seen high.
    task automatic count_clear(input string nm);
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ready === 1'b1) break;
        end
        chk(nm, 32'(cnt), 32'(DEPTH));
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    endtask

    initial begin
        int a;
        logic [1:0] sz;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_misalign", 32'(misalign), 32'h0);
        rst_n = 1'b1;
        count_clear("clear_cycles");

        // Cleared memory reads back zero.
        for (int w = 0; w < DEPTH; w++) ld(2'd2, 1'b0, 4 * w, 32'h0, "clear_lw");

        // Lane selection on a known word.
        st(2'd2, 16'h10, 32'h11223344);
        ld(2'd0, 1'b1, 16'h13, 32'h00000011, "lb_13");
        ld(2'd0, 1'b0, 16'h10, 32'h00000044, "lbu_10");
        ld(2'd1, 1'b1, 16'h12, 32'h00001122, "lh_12");
        ld(2'd2, 1'b0, 16'h10, 32'h11223344, "lw_10");

        // Partial stores and extension.
        st(2'd2, 16'h20, 32'h00000000);
        st(2'd0, 16'h21, 32'h000000F0);
        st(2'd1, 16'h22, 32'h00008001);
        ld(2'd2, 1'b0, 16'h20, 32'h8001F000, "lw_20");
        ld(2'd1, 1'b1, 16'h22, 32'hFFFF8001, "lh_22");
        ld(2'd1, 1'b0, 16'h22, 32'h00008001, "lhu_22");

        // Misaligned and illegal requests leave memory untouched.
        ld(2'd2, 1'b0, 16'h05, 32'h0, "lw_05");
        issue(1'b1, 2'd1, 1'b0, 16'h03, 32'h0000FFFF, 1'b0, 32'h0, "sh_03");
        issue(1'b1, 2'd3, 1'b0, 16'h00, 32'hFFFFFFFF, 1'b0, 32'h0, "sz11_00");
        ld(2'd2, 1'b0, 16'h00, 32'h0, "lw_00_unchanged");
        ld(2'd2, 1'b0, 16'h04, 32'h0, "lw_04_unchanged");

        // Store followed directly by a load of the same word.
        st(2'd2, 16'h08, 32'hCAFEBABE);
        ld(2'd2, 1'b0, 16'h08, 32'hCAFEBABE, "b2b_lw_08");
        idle(2);

        // Random traffic against the byte model.
        for (int n = 0; n < 400; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 63));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  1'b0, 32'h0, "rand");
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);

        // Fill with non-zero data so the restarted clear is visible.
        for (int w = 0; w < DEPTH; w++) st(2'd2, 4 * w, 32'hA5A50000 | 32'(w));
        idle(2);

        // Reset, then reset again in the middle of the clear.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ready", 32'(ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("restart_clear_cycles");
        for (int w = 0; w < DEPTH; w++) ld(2'd2, 1'b0, 4 * w, 32'h0, "restart_lw");
        idle(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
